divider_share_ctrl: RTL and testbench
=====================================

Name: divider_share_ctrl

Overview:
Sequences one shared sequential 8-bit divider (restoring, one quotient bit per clock) among NREQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Per-requester done/ack handshake.
- Exposes the QI/QC/QD state bits for LED display.
- Sits between PicoBlaze-driven or switch-driven requesters and the SSD/LED output logic in the divider top level.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, dividend/divisor/quotient/remainder width
IDXW, 2, width of owner index; must equal clog2(NREQ)

Ports:
ClkPort  in  1  board clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
req  in  NREQ  level request per requester
xin_bus  in  NREQ*WIDTH  dividends; requester i occupies bits [i*WIDTH +: WIDTH]
yin_bus  in  NREQ*WIDTH  divisors, same packing
ack  in  NREQ  result-consumed acknowledge per requester
grant  out  NREQ  one-hot, marks the current owner during QC/QD
done  out  NREQ  one-hot, result valid for the owner
quotient  out  WIDTH  shared result bus
remainder  out  WIDTH  shared result bus
div_by_zero  out  1  result flag, valid with done
owner  out  IDXW  index of current owner
Qi, Qc, Qd  out  1 each  one-hot state indicators

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State QI; Qi=1, Qc=0, Qd=0.
  - grant, done, quotient, remainder, div_by_zero, owner all 0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- QI (idle/arbitrate):
  - If any req bit is set, select the first set bit searching last+1, last+2, ... with wrap.
  - On the same edge: latch X and Y of the winner, set owner and grant.
  - Y!=0: go to QC. Load R=0 (WIDTH+1 bits), Q=X, D=Y, cnt=0.
  - Y==0: go directly to QD with quotient=all-ones, remainder=X, div_by_zero=1.
  - No req: stay in QI.
- QC (compute), one iteration per clock:
  - Shift {R,Q} left by 1.
  - If R>=D: R=R-D and Q[0]=1.
  - cnt increments each clock. After WIDTH iterations (cnt==WIDTH-1 on the edge), go to QD with quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
  - Latency: grant high at edge E; done high at edge E+WIDTH (8 clocks for WIDTH=8).
  - Abort: if req[owner] drops during QC, return to QI. grant clears, done is never raised, last=owner.
- QD (done):
  - done[owner]=1; quotient, remainder and div_by_zero are held stable.
  - ack[owner]=1: go to QI; done and grant clear on that edge; last=owner.
  - ack bits of non-owners are ignored in every state.
  - req[owner] dropping in QD has no effect; only ack releases.
- Simultaneous events:
  - Requests arriving during QC/QD wait, unserviced; they are not lost while held.
  - A requester holding req high after its ack is re-arbitrated behind the other active requesters.
  - Ack and a new req on the same edge: ack is processed, and arbitration happens on the next edge in QI. There is one idle QI cycle minimum between operations.
- Outputs:
  - quotient/remainder retain their last value in QI.
  - div_by_zero is cleared when the next operation starts.
  - Qi, Qc and Qd are exactly one-hot at all times.
- Widths: the subtract compares the WIDTH+1-bit R against the zero-extended D; no truncation before the compare.

Decomposition:
- Shared package divider_share_pkg holds:
  - the state encoding QI=3'b100, QC=3'b010, QD=3'b001, with Qi/Qc/Qd taken directly from the state bits;
  - the default WIDTH and NREQ constants.
- One sub-module, rr_arbiter_ctrl: combinational round-robin pick from req and last, producing a one-hot grant and an index. The FSM registers its output.

Test Plan:
- Single request: req0, X=200, Y=7 -> grant0 at E; done0 at E+8; quotient=0x1C, remainder=0x04, div_by_zero=0; ack0 -> QI next edge.
- Divide by zero: req1, X=0x37, Y=0 -> QI->QD directly; quotient=0xFF, remainder=0x37, div_by_zero=1, done1 at E.
- Boundaries: 255/1 -> 0xFF r0x00; 5/9 -> 0x00 r0x05; 255/255 -> 0x01 r0x00; 0/3 -> 0x00 r0x00.
- Round-robin: req[3:0] held at 4'b1111 with prompt acks -> grant order 0,1,2,3,0; no starvation.
- Handshake robustness: ack2 pulsed while owner=0 in QD -> ignored, done0 held. req0 dropped mid-QC -> return to QI, no done pulse.
- Reset mid-operation: Reset_n low during QC cnt=4 -> immediately Qi=1, all outputs 0. After release, a pending req0 is served first.

Source files
------------

// File: rtl/divider_share_pkg.sv
// Shared definitions for the shared-divider sequencer: state encoding and default sizes.
package divider_share_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREQ  = 4;

   // One-hot encoding so the LED indicators Qi/Qc/Qd can be taken straight from the state bits
   typedef enum logic [2:0] {
      QI = 3'b100,
      QC = 3'b010,
      QD = 3'b001
   } state_e;

endpackage

// File: rtl/rr_arbiter_ctrl.sv
// Combinational round-robin pick: searches req starting just after the last served index.
module rr_arbiter_ctrl #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] last_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);

   logic [IDXW-1:0] cand;

   // Walk last+1, last+2, ... with wrap and keep the first requester found
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDXW'((int'(last_i) + k) % NREQ);
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            idx_o         = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/divider_share_ctrl.sv
// Sequences one shared restoring divider (one quotient bit per clock) among NREQ requesters.
module divider_share_ctrl
   import divider_share_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDXW  = 2
) (
   input  logic                  ClkPort,
   input  logic                  Reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] xin_bus,
   input  logic [NREQ*WIDTH-1:0] yin_bus,
   input  logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      quotient,
   output logic [WIDTH-1:0]      remainder,
   output logic                  div_by_zero,
   output logic [IDXW-1:0]       owner,
   output logic                  Qi,
   output logic                  Qc,
   output logic                  Qd
);

   localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic [IDXW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [WIDTH:0]    partRem_q, partRem_d;
   logic [WIDTH-1:0]  partQuot_q, partQuot_d;
   logic [WIDTH-1:0]  divisor_q, divisor_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  quot_q, quot_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              dbz_q, dbz_d;

   logic [NREQ-1:0]   arbGrant;
   logic [IDXW-1:0]   arbIdx;
   logic              arbAny;

   logic [WIDTH-1:0]  xArr [NREQ];
   logic [WIDTH-1:0]  yArr [NREQ];

   logic [WIDTH:0]    remShift;
   logic [WIDTH-1:0]  quotShift;
   logic [WIDTH:0]    remSub;
   logic              fits;
   logic [WIDTH:0]    remIter;
   logic [WIDTH-1:0]  quotIter;

   rr_arbiter_ctrl #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) uArb (
      .req_i   (req),
      .last_i  (last_q),
      .grant_o (arbGrant),
      .idx_o   (arbIdx),
      .any_o   (arbAny)
   );

   // Unpack the flat operand buses into per-requester slots
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         xArr[i] = xin_bus[i*WIDTH +: WIDTH];
         yArr[i] = yin_bus[i*WIDTH +: WIDTH];
      end
   end

   // One restoring step: shift {R,Q} left, subtract D when the full-width R covers it
   always_comb begin
      remShift  = (partRem_q << 1) | {{WIDTH{1'b0}}, partQuot_q[WIDTH-1]};
      quotShift = {partQuot_q[WIDTH-2:0], 1'b0};
      remSub    = remShift - {1'b0, divisor_q};
      fits      = (remShift >= {1'b0, divisor_q});
      remIter   = fits ? remSub : remShift;
      quotIter  = quotShift | {{(WIDTH-1){1'b0}}, fits};
   end

   // Next-state logic: arbitrate in QI, iterate in QC, hold the result in QD until the owner acks
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      partRem_d  = partRem_q;
      partQuot_d = partQuot_q;
      divisor_d  = divisor_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      unique case (state_q)
         QI: begin
            if (arbAny) begin
               owner_d = arbIdx;
               grant_d = arbGrant;
               if (yArr[arbIdx] == '0) begin
                  state_d = QD;
                  quot_d  = '1;
                  rem_d   = xArr[arbIdx];
                  dbz_d   = 1'b1;
               end else begin
                  state_d    = QC;
                  partRem_d  = '0;
                  partQuot_d = xArr[arbIdx];
                  divisor_d  = yArr[arbIdx];
                  cnt_d      = '0;
                  dbz_d      = 1'b0;
               end
            end
         end
         QC: begin
            if (!req[owner_q]) begin
               state_d = QI;
               grant_d = '0;
               last_d  = owner_q;
            end else begin
               partRem_d  = remIter;
               partQuot_d = quotIter;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == CNTW'(WIDTH-1)) begin
                  state_d = QD;
                  quot_d  = quotIter;
                  rem_d   = remIter[WIDTH-1:0];
                  dbz_d   = 1'b0;
               end
            end
         end
         QD: begin
            if (ack[owner_q]) begin
               state_d = QI;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = QI;
            grant_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset leaves the pointer on the last slot so requester 0 wins first
   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= QI;
         last_q     <= IDXW'(NREQ-1);
         owner_q    <= '0;
         grant_q    <= '0;
         partRem_q  <= '0;
         partQuot_q <= '0;
         divisor_q  <= '0;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         partRem_q  <= partRem_d;
         partQuot_q <= partQuot_d;
         divisor_q  <= divisor_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
      end
   end

   // Done is the registered grant qualified by the done state, so it stays one-hot on the owner
   always_comb begin
      grant       = grant_q;
      done        = (state_q == QD) ? grant_q : '0;
      quotient    = quot_q;
      remainder   = rem_q;
      div_by_zero = dbz_q;
      owner       = owner_q;
      Qi          = state_q[2];
      Qc          = state_q[1];
      Qd          = state_q[0];
   end

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Self-checking bench for divider_share_ctrl: behavioural model plus directed vectors.
module tb_divider_share_ctrl;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDXW  = 2;

   logic                  ClkPort = 1'b0;
   logic                  Reset_n = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] xin_bus = '0;
   logic [NREQ*WIDTH-1:0] yin_bus = '0;
   logic [NREQ-1:0]       ack = '0;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      quotient;
   logic [WIDTH-1:0]      remainder;
   logic                  div_by_zero;
   logic [IDXW-1:0]       owner;
   logic                  Qi, Qc, Qd;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Model: phase 0 idle, 1 computing, 2 result held
   int         mPhase = 0;
   int         mLeft  = 0;
   int         mOwner = 0;
   int         mLast  = NREQ-1;
   logic [7:0] mQuot  = '0;
   logic [7:0] mRem   = '0;
   logic [7:0] mPendQ = '0;
   logic [7:0] mPendR = '0;
   logic       mDbz   = 1'b0;

   divider_share_ctrl #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) dut (
      .ClkPort     (ClkPort),
      .Reset_n     (Reset_n),
      .req         (req),
      .xin_bus     (xin_bus),
      .yin_bus     (yin_bus),
      .ack         (ack),
      .grant       (grant),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .owner       (owner),
      .Qi          (Qi),
      .Qc          (Qc),
      .Qd          (Qd)
   );

   // Free-running clock, period 10
   always #5 ClkPort = ~ClkPort;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPhase = 0;
      mLeft  = 0;
      mOwner = 0;
      mLast  = NREQ-1;
      mQuot  = '0;
      mRem   = '0;
      mDbz   = 1'b0;
   endtask

   task automatic modelStep();
      bit         found;
      int         w;
      int         c;
      logic [7:0] x, y;
      found = 1'b0;
      w     = 0;
      case (mPhase)
         0: begin
            for (int k = 1; k <= NREQ; k++) begin
               c = (mLast + k) % NREQ;
               if (!found && req[c]) begin
                  found = 1'b1;
                  w     = c;
               end
            end
            if (found) begin
               mOwner = w;
               x = xin_bus[w*WIDTH +: WIDTH];
               y = yin_bus[w*WIDTH +: WIDTH];
               if (y == 0) begin
                  mPhase = 2;
                  mQuot  = 8'hFF;
                  mRem   = x;
                  mDbz   = 1'b1;
               end else begin
                  mPhase = 1;
                  mLeft  = WIDTH;
                  mPendQ = x / y;
                  mPendR = x % y;
                  mDbz   = 1'b0;
               end
            end
         end
         1: begin
            if (!req[mOwner]) begin
               mPhase = 0;
               mLast  = mOwner;
            end else begin
               mLeft--;
               if (mLeft == 0) begin
                  mPhase = 2;
                  mQuot  = mPendQ;
                  mRem   = mPendR;
               end
            end
         end
         default: begin
            if (ack[mOwner]) begin
               mPhase = 0;
               mLast  = mOwner;
            end
         end
      endcase
   endtask

   // Advance the model on the same edges as the design, including the asynchronous reset
   always @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) modelReset();
      else          modelStep();
   end

   // Compare every output against the model on each falling edge
   always @(negedge ClkPort) begin
      logic [NREQ-1:0] expGrant;
      if (checkEn) begin
         expGrant = (mPhase != 0) ? NREQ'(1 << mOwner) : '0;
         checkOutput("Qi", Qi, mPhase == 0);
         checkOutput("Qc", Qc, mPhase == 1);
         checkOutput("Qd", Qd, mPhase == 2);
         checkOutput("grant", grant, expGrant);
         checkOutput("done", done, (mPhase == 2) ? expGrant : '0);
         checkOutput("quotient", quotient, mQuot);
         checkOutput("remainder", remainder, mRem);
         checkOutput("div_by_zero", div_by_zero, mDbz);
         if (mPhase != 0) checkOutput("owner", owner, mOwner);
      end
   end

   // Wait (bounded) for grant[idx] (which=0) or done[idx] (which=1); reports negedges waited
   task automatic waitBit(input int which, input int idx, input int budget,
                          output int cycles, output bit ok);
      ok     = 1'b0;
      cycles = 0;
      while (!ok && cycles < budget) begin
         @(negedge ClkPort);
         cycles++;
         if (which == 0 && grant[idx]) ok = 1'b1;
         if (which == 1 && done[idx])  ok = 1'b1;
      end
      if (!ok) checkOutput("wait_timeout", 0, 1);
   endtask

   task automatic doReset();
      @(negedge ClkPort);
      #2 Reset_n = 1'b0;
      #3 Reset_n = 1'b1;
   endtask

   // Run one division for requester idx and pin its result to hand-computed values
   task automatic applyStimulus(input int idx, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] expQ, input logic [7:0] expR,
                                input logic expDbz);
      int cyc, lat;
      bit ok;
      @(negedge ClkPort);
      xin_bus[idx*WIDTH +: WIDTH] = x;
      yin_bus[idx*WIDTH +: WIDTH] = y;
      req[idx] = 1'b1;
      waitBit(0, idx, 30, cyc, ok);
      if (ok) begin
         lat = 0;
         if (!done[idx]) waitBit(1, idx, 20, lat, ok);
         checkOutput("latency", lat, expDbz ? 0 : WIDTH);
         checkOutput("lit_quotient", quotient, expQ);
         checkOutput("lit_remainder", remainder, expR);
         checkOutput("lit_dbz", div_by_zero, expDbz);
      end
      ack[idx] = 1'b1;
      req[idx] = 1'b0;
      @(negedge ClkPort);
      ack[idx] = 1'b0;
      checkOutput("lit_idle_after_ack", Qi, 1);
   endtask

   initial begin
      int  cyc;
      bit  ok;
      int  expOrder [5] = '{0, 1, 2, 3, 0};
      int  seenDone;

      #1 Reset_n = 1'b0;
      checkEn = 1'b1;
      #3;
      checkOutput("lit_reset_Qi", Qi, 1);
      checkOutput("lit_reset_quotient", quotient, 0);
      #10 Reset_n = 1'b1;

      $display("[TB] division vectors");
      applyStimulus(0, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0);
      applyStimulus(1, 8'h37,  8'd0,   8'hFF, 8'h37, 1'b1);
      applyStimulus(2, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0);
      applyStimulus(3, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0);
      applyStimulus(0, 8'd255, 8'd255, 8'h01, 8'h00, 1'b0);
      applyStimulus(1, 8'd0,   8'd3,   8'h00, 8'h00, 1'b0);

      $display("[TB] round robin");
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         xin_bus[i*WIDTH +: WIDTH] = 8'(20 + 10*i);
         yin_bus[i*WIDTH +: WIDTH] = 8'd3;
      end
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         cyc = 0;
         while (done == '0 && cyc < 30) begin
            @(negedge ClkPort);
            cyc++;
         end
         if (done == '0) checkOutput("rr_timeout", 0, 1);
         checkOutput("lit_rr_owner", owner, expOrder[n]);
         ack = done;
         @(negedge ClkPort);
         ack = '0;
      end
      req = '0;
      repeat (2) @(negedge ClkPort);

      $display("[TB] foreign ack ignored");
      xin_bus[0 +: WIDTH] = 8'd100;
      yin_bus[0 +: WIDTH] = 8'd10;
      req[0] = 1'b1;
      waitBit(1, 0, 30, cyc, ok);
      req[0] = 1'b0;
      ack = 4'b0100;
      repeat (2) @(negedge ClkPort);
      checkOutput("lit_done_held", done, 4'b0001);
      checkOutput("lit_quot_held", quotient, 8'h0A);
      ack = 4'b0001;
      @(negedge ClkPort);
      ack = '0;
      checkOutput("lit_release", Qi, 1);

      $display("[TB] abort mid compute");
      xin_bus[0 +: WIDTH] = 8'd50;
      yin_bus[0 +: WIDTH] = 8'd5;
      req[0] = 1'b1;
      waitBit(0, 0, 30, cyc, ok);
      repeat (3) @(negedge ClkPort);
      req[0] = 1'b0;
      @(negedge ClkPort);
      checkOutput("lit_abort_Qi", Qi, 1);
      checkOutput("lit_abort_grant", grant, 0);
      seenDone = 0;
      repeat (10) begin
         @(negedge ClkPort);
         if (done != '0) seenDone++;
      end
      checkOutput("lit_abort_no_done", seenDone, 0);

      $display("[TB] reset mid compute");
      xin_bus[0 +: WIDTH] = 8'd77;
      yin_bus[0 +: WIDTH] = 8'd7;
      xin_bus[2*WIDTH +: WIDTH] = 8'd9;
      yin_bus[2*WIDTH +: WIDTH] = 8'd2;
      req[0] = 1'b1;
      waitBit(0, 0, 30, cyc, ok);
      repeat (4) @(negedge ClkPort);
      #2 Reset_n = 1'b0;
      #1;
      checkOutput("lit_rst_Qi", Qi, 1);
      checkOutput("lit_rst_Qc", Qc, 0);
      checkOutput("lit_rst_grant", grant, 0);
      checkOutput("lit_rst_quotient", quotient, 0);
      checkOutput("lit_rst_remainder", remainder, 0);
      req = 4'b0101;
      #4 Reset_n = 1'b1;
      waitBit(0, 0, 30, cyc, ok);
      checkOutput("lit_post_rst_owner", owner, 0);
      waitBit(1, 0, 20, cyc, ok);
      checkOutput("lit_post_rst_quot", quotient, 8'd11);
      ack = 4'b0001;
      req = 4'b0100;
      @(negedge ClkPort);
      ack = '0;
      waitBit(1, 2, 30, cyc, ok);
      checkOutput("lit_req2_quot", quotient, 8'd4);
      checkOutput("lit_req2_rem", remainder, 8'd1);
      ack = 4'b0100;
      req = '0;
      @(negedge ClkPort);
      ack = '0;
      repeat (2) @(negedge ClkPort);

      checkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global guard so the run cannot hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
